dff_write_arbiter: RTL and testbench

Round-robin write arbiter and controller for a shared WIDTH-bit D-flip-flop register with true and complement outputs (q/qnot). Up to NREQ requesters compete for write access. The block sequences each write as request, one-cycle grant, register capture and one-cycle acknowledge. It sits between several producer blocks and the single shared state register they all update.

---
 rtl/dff_arb_pkg.sv | 13 +
 rtl/dff_reg.sv | 35 +++
 rtl/dff_write_arbiter.sv | 121 ++++++++++++
 tb/tb_dff_write_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dff_arb_pkg.sv
// Shared definitions for the shared-register write arbiter: FSM state encoding
// and its width.
package dff_arb_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

endpackage

// File: rtl/dff_reg.sv
// WIDTH-bit shared state register with load enable and a complement output
// that tracks q at all times, including during reset.
module dff_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qnot
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign qnot = ~q_q;

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter in front of a single shared register: each write
// runs IDLE -> GRANT -> ACK, and the register captures at the end of GRANT.
module dff_write_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         ack,
  output logic [WIDTH-1:0]        q,
  output logic [WIDTH-1:0]        qnot,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_pick;
  logic             rr_found;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] slice [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign slice[gi] = wdata[gi*WIDTH +: WIDTH];
      assign grant[gi] = (state_q == ST_GRANT) && (winner_q == IDX_W'(gi));
      assign ack[gi]   = (state_q == ST_ACK)   && (winner_q == IDX_W'(gi));
    end
  endgenerate

  // Search starts just after the last successful writer; the wrap is an
  // explicit compare so non-power-of-two NREQ never indexes past the end.
  always_comb begin
    logic [IDX_W-1:0] cand;
    rr_pick  = '0;
    rr_found = 1'b0;
    cand     = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    owner_d  = owner_q;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          winner_d = rr_pick;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A winner that dropped req before the closing edge forfeits the slot.
        if (req[winner_q]) begin
          load    = 1'b1;
          ptr_d   = winner_q;
          owner_d = winner_q;
          state_d = ST_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= LAST_IDX;
      winner_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      owner_q  <= owner_d;
    end
  end

  assign load_data = slice[winner_q];
  assign busy      = (state_q != ST_IDLE);
  assign owner     = owner_q;

  dff_reg #(
    .WIDTH(WIDTH)
  ) u_reg (
    .clk (clk),
    .rst (rst),
    .load(load),
    .d   (load_data),
    .q   (q),
    .qnot(qnot)
  );

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Bench for dff_write_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level model.
module tb_dff_write_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic [7:0]  qnot;
  logic        busy;
  logic [1:0]  owner;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dff_write_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .wdata(wdata),
    .grant(grant),
    .ack  (ack),
    .q    (q),
    .qnot (qnot),
    .busy (busy),
    .owner(owner)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        busy;
    logic [1:0]  owner;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] WD_RR  = 32'h1312_1110;
  localparam logic [31:0] WD_ONE = 32'h00A5_0000;

  task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] wd,
                     input logic [3:0] g, input logic [3:0] a, input logic [7:0] qv,
                     input logic b, input logic [1:0] o);
    vec_t v;
    v.rst = r; v.req = rq; v.wdata = wd; v.grant = g; v.ack = a;
    v.q = qv; v.busy = b; v.owner = o;
    vecs.push_back(v);
  endtask

  // Apply inputs, let one rising edge pass, land 1 time unit after it.
  task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] wd);
    rst = r; req = rq; wdata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [3:0] g, input logic [3:0] a,
                            input logic [7:0] qv, input logic b, input logic [1:0] o);
    logic [26:0] got, exp;
    got = {grant, ack, q, qnot, busy, owner};
    exp = {g, a, qv, ~qv, b, o};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got grant=%b ack=%b q=%h qnot=%h busy=%b owner=%0d, expected grant=%b ack=%b q=%h qnot=%h busy=%b owner=%0d",
               name, grant, ack, q, qnot, busy, owner, g, a, qv, ~qv, b, o);
    end else if (a != 4'b0) begin
      $display("write %s: ack=%b q=%h owner=%0d", name, ack, q, owner);
    end
  endtask

  // Reference model: a write transaction is (pick winner, commit, acknowledge).
  int         m_phase;   // 0 waiting, 1 granted, 2 acknowledging
  int         m_win;
  int         m_ptr;
  int         m_owner;
  logic [7:0] m_q;

  task automatic model_reset();
    m_phase = 0; m_win = 0; m_ptr = NREQ - 1; m_owner = 0; m_q = 8'h00;
  endtask

  task automatic model_edge(input logic r, input logic [3:0] rq, input logic [31:0] wd);
    if (r) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (rq != 4'b0) begin
        bit found = 0;
        for (int k = 1; k <= NREQ; k++) begin
          int c = (m_ptr + k) % NREQ;
          if (!found && rq[c]) begin
            found = 1;
            m_win = c;
          end
        end
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (rq[m_win]) begin
        m_q     = wd[m_win*8 +: 8];
        m_ptr   = m_win;
        m_owner = m_win;
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  initial begin
    logic [3:0]  rq_prev;
    logic [3:0]  rq;
    logic [31:0] wd;
    logic        r;
    logic [3:0]  eg, ea;

    rst = 1'b1; req = 4'b0; wdata = 32'b0;

    // reset with everyone requesting
    add(1, 4'hF, WD_RR,  4'h0, 4'h0, 8'h00, 0, 2'd0);
    add(1, 4'hF, WD_RR,  4'h0, 4'h0, 8'h00, 0, 2'd0);
    // single request from requester 2
    add(0, 4'h4, WD_ONE, 4'h4, 4'h0, 8'h00, 1, 2'd0);
    add(0, 4'h4, WD_ONE, 4'h0, 4'h4, 8'hA5, 1, 2'd2);
    add(0, 4'h0, WD_ONE, 4'h0, 4'h0, 8'hA5, 0, 2'd2);
    add(0, 4'h0, WD_ONE, 4'h0, 4'h0, 8'hA5, 0, 2'd2);
    // round robin with wrap, starting from reset pointer
    add(1, 4'h0, WD_RR,  4'h0, 4'h0, 8'h00, 0, 2'd0);
    add(0, 4'hF, WD_RR,  4'h1, 4'h0, 8'h00, 1, 2'd0);
    add(0, 4'hF, WD_RR,  4'h0, 4'h1, 8'h10, 1, 2'd0);
    add(0, 4'hF, WD_RR,  4'h0, 4'h0, 8'h10, 0, 2'd0);
    add(0, 4'hF, WD_RR,  4'h2, 4'h0, 8'h10, 1, 2'd0);
    add(0, 4'hF, WD_RR,  4'h0, 4'h2, 8'h11, 1, 2'd1);
    add(0, 4'hF, WD_RR,  4'h0, 4'h0, 8'h11, 0, 2'd1);
    add(0, 4'hF, WD_RR,  4'h4, 4'h0, 8'h11, 1, 2'd1);
    add(0, 4'hF, WD_RR,  4'h0, 4'h4, 8'h12, 1, 2'd2);
    add(0, 4'hF, WD_RR,  4'h0, 4'h0, 8'h12, 0, 2'd2);
    add(0, 4'hF, WD_RR,  4'h8, 4'h0, 8'h12, 1, 2'd2);
    add(0, 4'hF, WD_RR,  4'h0, 4'h8, 8'h13, 1, 2'd3);
    add(0, 4'hF, WD_RR,  4'h0, 4'h0, 8'h13, 0, 2'd3);
    add(0, 4'hF, WD_RR,  4'h1, 4'h0, 8'h13, 1, 2'd3);
    add(0, 4'hF, WD_RR,  4'h0, 4'h1, 8'h10, 1, 2'd0);
    add(0, 4'h0, WD_RR,  4'h0, 4'h0, 8'h10, 0, 2'd0);
    // requester 1 writes, then 3 and 0 compete: 3 comes first
    add(0, 4'h2, WD_RR,  4'h2, 4'h0, 8'h10, 1, 2'd0);
    add(0, 4'h2, WD_RR,  4'h0, 4'h2, 8'h11, 1, 2'd1);
    add(0, 4'h9, WD_RR,  4'h0, 4'h0, 8'h11, 0, 2'd1);
    add(0, 4'h9, WD_RR,  4'h8, 4'h0, 8'h11, 1, 2'd1);
    add(0, 4'h9, WD_RR,  4'h0, 4'h8, 8'h13, 1, 2'd3);
    add(0, 4'h9, WD_RR,  4'h0, 4'h0, 8'h13, 0, 2'd3);
    add(0, 4'h9, WD_RR,  4'h1, 4'h0, 8'h13, 1, 2'd3);
    add(0, 4'h9, WD_RR,  4'h0, 4'h1, 8'h10, 1, 2'd0);
    add(0, 4'h0, WD_RR,  4'h0, 4'h0, 8'h10, 0, 2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].wdata);
      expect_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].ack, vecs[i].q,
                 vecs[i].busy, vecs[i].owner);
    end

    // withdrawal: requester 3 writes, then requester 1 drops req in GRANT
    step(1, 4'h0, 32'h0);          expect_out("wd_rst",    4'h0, 4'h0, 8'h00, 0, 2'd0);
    step(0, 4'h8, 32'h7700_0000);  expect_out("wd_g3",     4'h8, 4'h0, 8'h00, 1, 2'd0);
    step(0, 4'h8, 32'h7700_0000);  expect_out("wd_a3",     4'h0, 4'h8, 8'h77, 1, 2'd3);
    step(0, 4'h0, 32'h0);          expect_out("wd_idle",   4'h0, 4'h0, 8'h77, 0, 2'd3);
    step(0, 4'h2, 32'h0000_EE00);  expect_out("wd_g1",     4'h2, 4'h0, 8'h77, 1, 2'd3);
    step(0, 4'h0, 32'h0000_EE00);  expect_out("wd_drop",   4'h0, 4'h0, 8'h77, 0, 2'd3);
    step(0, 4'hF, 32'h4433_2211);  expect_out("wd_next_g", 4'h1, 4'h0, 8'h77, 1, 2'd3);
    step(0, 4'hF, 32'h4433_2211);  expect_out("wd_next_a", 4'h0, 4'h1, 8'h11, 1, 2'd0);
    step(0, 4'h0, 32'h0);          expect_out("wd_end",    4'h0, 4'h0, 8'h11, 0, 2'd0);

    // reset while requester 1 holds the grant; pointer must return to 3
    step(0, 4'h2, 32'h0000_3C00);  expect_out("rm_g1",     4'h2, 4'h0, 8'h11, 1, 2'd0);
    step(1, 4'h2, 32'h0000_3C00);  expect_out("rm_rst",    4'h0, 4'h0, 8'h00, 0, 2'd0);
    step(0, 4'h3, 32'h0000_0066);  expect_out("rm_g0",     4'h1, 4'h0, 8'h00, 1, 2'd0);
    step(0, 4'h3, 32'h0000_0066);  expect_out("rm_a0",     4'h0, 4'h1, 8'h66, 1, 2'd0);
    step(0, 4'h0, 32'h0);          expect_out("rm_end",    4'h0, 4'h0, 8'h66, 0, 2'd0);

    // randomized traffic against the model
    model_reset();
    step(1, 4'h0, 32'h0);
    expect_out("rnd_rst", 4'h0, 4'h0, 8'h00, 0, 2'd0);
    rq_prev = 4'h0;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      rq = ($urandom_range(0, 1) == 1) ? rq_prev : 4'($urandom);
      wd = $urandom;
      rq_prev = rq;
      model_edge(r, rq, wd);
      step(r, rq, wd);
      eg = (m_phase == 1) ? (4'b0001 << m_win) : 4'b0;
      ea = (m_phase == 2) ? (4'b0001 << m_win) : 4'b0;
      expect_out($sformatf("rnd%0d", i), eg, ea, m_q, (m_phase != 0), 2'(m_owner));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
